// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  function automatic int unsigned word_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned lines, input int unsigned words);
    return ADDR_W - OFF_W - word_w(words) - idx_w(lines);
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage for the cache; valid bits clear asynchronously,
// tags and data are never reset.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 32,
  parameter int unsigned WORDS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [idx_w(LINES)-1:0]         idx,
  input  logic [word_w(WORDS)-1:0]        rd_word,
  output logic                            rd_valid_c,
  output logic [tag_w(LINES, WORDS)-1:0]  rd_tag_c,
  output logic [DATA_W-1:0]               rd_data_c,
  input  logic                            fill_en,
  input  logic [word_w(WORDS)-1:0]        fill_word,
  input  logic [DATA_W-1:0]               fill_data,
  input  logic                            st_en,
  input  logic [word_w(WORDS)-1:0]        st_word,
  input  logic [DATA_W-1:0]               st_data,
  input  logic                            tag_set,
  input  logic [tag_w(LINES, WORDS)-1:0]  tag_data,
  input  logic                            inval
);

  localparam int unsigned TAG_W = tag_w(LINES, WORDS);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][WORDS];

  // Valid bit: cleared on a miss so a partial fill never looks valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (tag_set) begin
      valid_q[idx] <= 1'b1;
    end else if (inval) begin
      valid_q[idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_set) begin
      tag_q[idx] <= tag_data;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[idx][fill_word] <= fill_data;
    end else if (st_en) begin
      data_q[idx][st_word] <= st_data;
    end
  end

  assign rd_valid_c = valid_q[idx];
  assign rd_tag_c   = tag_q[idx];
  assign rd_data_c  = data_q[idx][rd_word];

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache with line fill
// on load miss and saturating hit/miss statistics.
module dcache_direct
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 32,
  parameter int unsigned WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned WORD_W = word_w(WORDS);
  localparam int unsigned IDX_W  = idx_w(LINES);
  localparam int unsigned TAG_W  = tag_w(LINES, WORDS);

  logic [WORD_W-1:0] a_word;
  logic [IDX_W-1:0]  a_idx;
  logic [TAG_W-1:0]  a_tag;
  logic              addr_unused_c;

  assign a_word        = cpu_addr[OFF_W +: WORD_W];
  assign a_idx         = cpu_addr[OFF_W + WORD_W +: IDX_W];
  assign a_tag         = cpu_addr[ADDR_W-1 -: TAG_W];
  assign addr_unused_c = ^cpu_addr[OFF_W-1:0];

  state_e            state, state_nxt;
  logic [WORD_W-1:0] cnt, cnt_nxt;

  logic              rd_valid_c;
  logic [TAG_W-1:0]  rd_tag_c;
  logic [DATA_W-1:0] rd_data_c;
  logic              hit_c;
  logic              fill_en, st_en, tag_set, inval;
  logic              hit_inc, miss_inc;

  assign hit_c = rd_valid_c && (rd_tag_c == a_tag);

  dcache_line_array #(
    .LINES(LINES),
    .WORDS(WORDS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .idx        (a_idx),
    .rd_word    (a_word),
    .rd_valid_c (rd_valid_c),
    .rd_tag_c   (rd_tag_c),
    .rd_data_c  (rd_data_c),
    .fill_en    (fill_en),
    .fill_word  (cnt),
    .fill_data  (mem_rdata),
    .st_en      (st_en),
    .st_word    (a_word),
    .st_data    (cpu_wdata),
    .tag_set    (tag_set),
    .tag_data   (a_tag),
    .inval      (inval)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and the combinational cache/memory handshake; all quiet in reset.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cpu_rdata = '0;
    cpu_stall = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    fill_en   = 1'b0;
    st_en     = 1'b0;
    tag_set   = 1'b0;
    inval     = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    if (rst) begin
      case (state)
        ST_IDLE: begin
          if (cpu_write) begin
            mem_write = 1'b1;
            mem_addr  = {a_tag, a_idx, a_word, 2'b00};
            mem_wdata = cpu_wdata;
            st_en     = hit_c;
          end else if (cpu_read) begin
            if (hit_c) begin
              cpu_rdata = rd_data_c;
              hit_inc   = 1'b1;
            end else begin
              cpu_stall = 1'b1;
              miss_inc  = 1'b1;
              inval     = 1'b1;
              cnt_nxt   = '0;
              state_nxt = ST_FILL;
            end
          end
        end
        ST_FILL: begin
          cpu_stall = 1'b1;
          mem_read  = 1'b1;
          mem_addr  = {a_tag, a_idx, cnt, 2'b00};
          fill_en   = 1'b1;
          if (cnt == WORD_W'(WORDS - 1)) begin
            tag_set   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + WORD_W'(1);
          end
        end
      endcase
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc && hit_count != '1) begin
        hit_count <= hit_count + CNT_W'(1);
      end
      if (miss_inc && miss_count != '1) begin
        miss_count <= miss_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dcache_direct.sv
// Directed bench for dcache_direct: behavioural memory, scoreboard of load data.
module tb_dcache_direct;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int ncmp = 0;
  int nerr = 0;

  logic [31:0] sb [$];
  logic [31:0] gold [logic [31:0]];

  logic        tb_init;
  logic [31:0] wmem [0:1023];
  logic [1023:0] written;

  dcache_direct dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] gexp(input logic [31:0] a);
    if (gold.exists(a)) return gold[a];
    return pat(a);
  endfunction

  // Memory: combinational read, write on the rising edge.
  always_comb begin
    mem_rdata = written[mem_addr[11:2]] ? wmem[mem_addr[11:2]] : pat({mem_addr[31:2], 2'b00});
  end

  always @(posedge clk) begin
    if (tb_init) begin
      written <= '0;
    end else if (mem_write) begin
      written[mem_addr[11:2]] <= 1'b1;
      wmem[mem_addr[11:2]]    <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] a, input int exp_stall);
    int st;
    int k;
    logic [31:0] e;
    sb.push_back(gexp(a));
    @(negedge clk);
    cpu_addr  = a;
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    #1;
    st = 0;
    k  = 0;
    while (cpu_stall && st < 20) begin
      if (mem_read) begin
        chk("fill_addr", mem_addr, {a[31:4], 4'b0000} + 32'(4 * k));
        k++;
      end
      @(negedge clk);
      #1;
      st++;
    end
    chk("stall_cycles", 32'(st), 32'(exp_stall));
    e = sb.pop_front();
    chk("load_rdata", cpu_rdata, e);
    chk("mem_read_idle", 32'(mem_read), 32'd0);
    @(negedge clk);
    cpu_read = 1'b0;
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic rd_too);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    @(negedge clk);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_write = 1'b1;
    cpu_read  = rd_too;
    #1;
    chk("st_stall", 32'(cpu_stall), 32'd0);
    chk("st_mem_write", 32'(mem_write), 32'd1);
    chk("st_mem_read", 32'(mem_read), 32'd0);
    chk("st_mem_addr", mem_addr, wa);
    chk("st_mem_wdata", mem_wdata, d);
    gold[wa] = d;
    @(negedge clk);
    cpu_write = 1'b0;
    cpu_read  = 1'b0;
    #1;
    chk("mem_after_store", written[wa[11:2]] ? wmem[wa[11:2]] : 32'hXXXX_XXXX, d);
  endtask

  task automatic chk_counts(input string tag, input int h, input int m);
    chk({tag, "_hits"}, 32'(hit_count), 32'(h));
    chk({tag, "_misses"}, 32'(miss_count), 32'(m));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clk       = 1'b0;
    rst       = 1'b0;
    tb_init   = 1'b1;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    repeat (3) @(negedge clk);
    // A load request held during reset must still see a quiet cache.
    cpu_addr = 32'h40;
    cpu_read = 1'b1;
    #1;
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk_counts("rst", 0, 0);
    @(negedge clk);
    cpu_read = 1'b0;
    tb_init  = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    do_load(32'h40, 5);
    chk_counts("cold", 1, 1);
    do_load(32'h44, 0);
    chk_counts("hit44", 2, 1);

    do_load(32'h40, 0);
    do_load(32'h240, 5);
    do_load(32'h40, 5);
    chk_counts("conflict", 5, 3);

    do_store(32'h48, 32'hDEADBEEF, 1'b0);
    do_load(32'h48, 0);
    chk_counts("store_hit", 6, 3);
    do_store(32'h44, 32'hCAFEF00D, 1'b1);
    chk_counts("rd_wr_both", 6, 3);
    do_load(32'h44, 0);
    do_store(32'h100, 32'h12345678, 1'b0);
    do_load(32'h100, 5);
    chk_counts("store_miss", 8, 4);

    // Reset in the third fill cycle of a miss on 0x80.
    @(negedge clk);
    cpu_addr = 32'h80;
    cpu_read = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("fill_cnt2_addr", mem_addr, 32'h88);
    chk("fill_cnt2_read", 32'(mem_read), 32'd1);
    rst = 1'b0;
    #1;
    chk("midfill_stall", 32'(cpu_stall), 32'd0);
    chk("midfill_mem_read", 32'(mem_read), 32'd0);
    chk("midfill_mem_addr", mem_addr, 32'd0);
    chk("midfill_rdata", cpu_rdata, 32'd0);
    chk_counts("midfill", 0, 0);
    @(negedge clk);
    cpu_read = 1'b0;
    rst      = 1'b1;
    do_load(32'h80, 5);
    chk_counts("reload80", 1, 1);
    do_load(32'h40, 5);
    chk_counts("postrst40", 2, 2);

    // Saturation of the hit counter.
    @(negedge clk);
    cpu_addr = 32'h84;
    cpu_read = 1'b1;
    repeat (65540) @(negedge clk);
    #1;
    chk("sat_stall", 32'(cpu_stall), 32'd0);
    chk("sat_rdata", cpu_rdata, gexp(32'h84));
    chk_counts("saturate", 16'hFFFF, 2);
    cpu_read = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
